// File: rtl/uart_bus_master.sv
// rtl/uart_bus_master.sv - UART byte-stream to native valid/ready memory bus bridge
module uart_bus_master #(
    parameter int unsigned TIMEOUT     = 1024,
    parameter int unsigned GAP_TIMEOUT = 100000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

    localparam logic [7:0]  CMD_W     = 8'h57;
    localparam logic [7:0]  CMD_R     = 8'h52;
    localparam logic [7:0]  RSP_K     = 8'h4B;
    localparam logic [7:0]  RSP_Q     = 8'h3F;
    localparam logic [7:0]  RSP_T     = 8'h54;
    localparam logic [31:0] BUS_LIMIT = 32'(TIMEOUT - 1);
    localparam logic [31:0] GAP_LIMIT = 32'(GAP_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        is_write_q, is_write_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] resp_q, resp_d;
    logic [2:0]  resp_left_q, resp_left_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic [31:0] gap_cnt_q, gap_cnt_d;
    logic        mem_valid_q, mem_valid_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;

    logic        rx_fire;
    logic        gap_expired;
    logic        bus_expired;
    logic [7:0]  byte_in;

    assign rx_ready    = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_DATA);
    assign rx_fire     = rx_valid && rx_ready;
    assign gap_expired = (GAP_TIMEOUT != 0) && (gap_cnt_q == GAP_LIMIT);
    assign bus_expired = (TIMEOUT != 0) && (wait_cnt_q == BUS_LIMIT);
    // Host-supplied address bits [1:0] are dropped as the first address byte arrives.
    assign byte_in     = (state_q == S_ADDR && cnt_q == 2'd0) ? {rx_data[7:2], 2'b00} : rx_data;

    always_comb begin
        state_d     = state_q;
        is_write_d  = is_write_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        resp_d      = resp_q;
        resp_left_d = resp_left_q;
        wait_cnt_d  = wait_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        mem_valid_d = mem_valid_q;
        mem_wstrb_d = mem_wstrb_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (rx_fire) begin
                    if (rx_data == CMD_W || rx_data == CMD_R) begin
                        is_write_d = (rx_data == CMD_W);
                        cnt_d      = 2'd0;
                        gap_cnt_d  = 32'd0;
                        state_d    = S_ADDR;
                    end else begin
                        tx_valid_d  = 1'b1;
                        tx_data_d   = RSP_Q;
                        resp_left_d = 3'd1;
                        state_d     = S_RESP;
                    end
                end
            end
            S_ADDR, S_DATA: begin
                if (rx_fire) begin
                    if (state_q == S_ADDR) begin
                        addr_d[{cnt_q, 3'b000} +: 8] = byte_in;
                    end else begin
                        wdata_d[{cnt_q, 3'b000} +: 8] = byte_in;
                    end
                    cnt_d     = cnt_q + 2'd1;
                    gap_cnt_d = 32'd0;
                    if (cnt_q == 2'd3) begin
                        if (state_q == S_ADDR && is_write_q) begin
                            state_d = S_DATA;
                        end else begin
                            state_d     = S_BUS;
                            mem_valid_d = 1'b1;
                            mem_wstrb_d = is_write_q ? 4'b1111 : 4'b0000;
                            wait_cnt_d  = 32'd0;
                        end
                    end
                end else if (gap_expired) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 32'd1;
                end
            end
            S_BUS: begin
                // Completion wins over a timeout reached in the same cycle.
                if (mem_valid_q && mem_ready) begin
                    mem_valid_d = 1'b0;
                    tx_valid_d  = 1'b1;
                    state_d     = S_RESP;
                    if (is_write_q) begin
                        tx_data_d   = RSP_K;
                        resp_left_d = 3'd1;
                    end else begin
                        tx_data_d   = mem_rdata[7:0];
                        resp_d      = {8'h00, mem_rdata[31:8]};
                        resp_left_d = 3'd4;
                    end
                end else if (bus_expired) begin
                    mem_valid_d = 1'b0;
                    tx_valid_d  = 1'b1;
                    tx_data_d   = RSP_T;
                    resp_left_d = 3'd1;
                    state_d     = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end
            S_RESP: begin
                if (tx_valid_q && tx_ready) begin
                    if (resp_left_q == 3'd1) begin
                        tx_valid_d = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        tx_data_d   = resp_q[7:0];
                        resp_d      = {8'h00, resp_q[31:8]};
                        resp_left_d = resp_left_q - 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            is_write_q  <= 1'b0;
            cnt_q       <= 2'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            resp_q      <= 32'd0;
            resp_left_q <= 3'd0;
            wait_cnt_q  <= 32'd0;
            gap_cnt_q   <= 32'd0;
            mem_valid_q <= 1'b0;
            mem_wstrb_q <= 4'b0000;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            is_write_q  <= is_write_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            resp_q      <= resp_d;
            resp_left_q <= resp_left_d;
            wait_cnt_q  <= wait_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            mem_valid_q <= mem_valid_d;
            mem_wstrb_q <= mem_wstrb_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_bus_master.sv
// tb/tb_uart_bus_master.sv - self-checking bench for uart_bus_master
module tb_uart_bus_master;
    localparam int TMO = 16;
    localparam int GAP = 50;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b1;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        busy;

    always #5 clk = ~clk;

    uart_bus_master #(.TIMEOUT(TMO), .GAP_TIMEOUT(GAP)) dut (
        .clk(clk), .reset_n(reset_n),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } txn_t;

    typedef struct {
        logic [71:0] cmd;
        int          len;
        int          dly;
        bit          rnd;
        int          np;
        int          ntx;
        logic [31:0] etx;
        bit          etxn;
        logic [31:0] ea;
        logic [31:0] ew;
        logic [3:0]  es;
        int          ev;
    } vec_t;

    int total = 0;
    int bad = 0;

    int rsp_delay = 0;
    bit tx_rand = 1'b0;
    logic [31:0] rsp_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    txn_t        bus_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  cmdq[$];
    int cur_v = 0, last_v = 0, pulses = 0, bus_unstable = 0, tx_unstable = 0;
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_wstrb;
    bit          tx_pend = 1'b0;
    logic [7:0]  tx_pend_data;

    logic [7:0]  m_tx[$];
    bit          m_txn;
    int          m_pulse;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rsp_rd(input logic [31:0] a);
        return rsp_mem.exists(a) ? rsp_mem[a] : ~a;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : ~a;
    endfunction

    // Bus responder: ready after rsp_delay valid cycles (never if negative); noise on mem_ready while idle.
    always @(negedge clk) begin
        if (mem_valid === 1'b1) begin
            if (cur_v == 0) begin
                p_addr = mem_addr; p_wdata = mem_wdata; p_wstrb = mem_wstrb;
            end else if (mem_addr !== p_addr || mem_wdata !== p_wdata || mem_wstrb !== p_wstrb) begin
                bus_unstable++;
            end
            if (mem_addr[1:0] !== 2'b00) bus_unstable++;
            if (rsp_delay >= 0 && cur_v >= rsp_delay) begin
                mem_ready = 1'b1;
                mem_rdata = rsp_rd(mem_addr);
                bus_q.push_back('{mem_addr, mem_wdata, mem_wstrb});
                if (mem_wstrb == 4'hF) rsp_mem[mem_addr] = mem_wdata;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end
            cur_v++;
        end else begin
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            if (cur_v != 0) begin
                last_v = cur_v; pulses++; cur_v = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (tx_pend && (tx_valid !== 1'b1 || tx_data !== tx_pend_data)) tx_unstable++;
        tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (tx_valid === 1'b1 && tx_ready) tx_q.push_back(tx_data);
        tx_pend      = (tx_valid === 1'b1) && !tx_ready && reset_n;
        tx_pend_data = tx_data;
    end

    // Reference: what the host should see for the command in cmdq, given responder latency dly.
    task automatic model_cmd(input int dly);
        logic [31:0] a, w, d;
        m_tx.delete();
        m_txn = 1'b0;
        m_pulse = 0;
        if (cmdq[0] == 8'h57 || cmdq[0] == 8'h52) begin
            a = {cmdq[4], cmdq[3], cmdq[2], cmdq[1]} & 32'hFFFF_FFFC;
            m_pulse = 1;
            m_txn = (dly >= 0);
            m_addr = a;
            if (cmdq[0] == 8'h57) begin
                w = {cmdq[8], cmdq[7], cmdq[6], cmdq[5]};
                m_wdata = w;
                m_wstrb = 4'hF;
                if (m_txn) begin
                    ref_mem[a] = w;
                    m_tx.push_back(8'h4B);
                end else m_tx.push_back(8'h54);
            end else begin
                m_wstrb = 4'h0;
                if (m_txn) begin
                    d = ref_rd(a);
                    for (int j = 0; j < 4; j++) m_tx.push_back(8'((d >> (8 * j)) & 32'hFF));
                end else m_tx.push_back(8'h54);
            end
        end else m_tx.push_back(8'h3F);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("rx_accept_bound", 32'(n < 2000), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_all();
        for (int j = 0; j < cmdq.size(); j++) send_byte(cmdq[j]);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < 3000), 32'd1);
    endtask

    function automatic logic [31:0] tx_word();
        logic [31:0] o = 32'h0;
        for (int j = 0; j < tx_q.size() && j < 4; j++) o[8 * j +: 8] = tx_q[j];
        return o;
    endfunction

    vec_t vecs[5];

    initial begin
        int p0, kind, dly;
        logic [31:0] a, w;
        logic [7:0] b;

        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, kind, dly;
        logic [31:0] a, w;
        logic [7:0] b;

        vecs[0] = '{72'hDEADBEEF_00000010_57, 9, 3, 1'b0, 1, 1, 32'h4B, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 4};
        vecs[1] = '{72'h00000000_02000008_52, 5, 0, 1'b1, 1, 4, 32'h12345678, 1'b1, 32'h02000008, 32'h0, 4'h0, 1};
        vecs[2] = '{72'h00000000_03000000_52, 5, -1, 1'b0, 1, 1, 32'h54, 1'b0, 32'h0, 32'h0, 4'h0, TMO};
        vecs[3] = '{72'h00000000_00000000_41, 1, 0, 1'b0, 0, 1, 32'h3F, 1'b0, 32'h0, 32'h0, 4'h0, -1};
        vecs[4] = '{72'h44332211_00000003_57, 9, 1, 1'b0, 1, 1, 32'h4B, 1'b1, 32'h0, 32'h44332211, 4'hF, 2};
        rsp_mem[32'h02000008] = 32'h12345678;

        repeat (3) @(negedge clk);
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            rsp_delay = vecs[i].dly;
            tx_rand   = vecs[i].rnd;
            tx_q.delete();
            bus_q.delete();
            cmdq.delete();
            for (int j = 0; j < vecs[i].len; j++) cmdq.push_back(vecs[i].cmd[8 * j +: 8]);
            p0 = pulses;
            send_all();
            wait_idle($sformatf("row%0d_idle", i));
            chk($sformatf("row%0d_ntx", i), tx_q.size(), vecs[i].ntx);
            chk($sformatf("row%0d_tx", i), tx_word(), vecs[i].etx);
            chk($sformatf("row%0d_pulses", i), pulses - p0, vecs[i].np);
            chk($sformatf("row%0d_ntxn", i), bus_q.size(), 32'(vecs[i].etxn));
            if (vecs[i].etxn && bus_q.size() == 1) begin
                chk($sformatf("row%0d_addr", i), bus_q[0].addr, vecs[i].ea);
                chk($sformatf("row%0d_wstrb", i), 32'(bus_q[0].wstrb), 32'(vecs[i].es));
                if (vecs[i].es == 4'hF) chk($sformatf("row%0d_wdata", i), bus_q[0].wdata, vecs[i].ew);
            end
            if (vecs[i].ev >= 0) chk($sformatf("row%0d_valid_cycles", i), last_v, vecs[i].ev);
        end

        // Gap timeout: a stalled write header is dropped silently, the next read runs.
        rsp_delay = 0;
        tx_rand = 1'b0;
        tx_q.delete();
        bus_q.delete();
        p0 = pulses;
        cmdq = '{8'h57, 8'h10};
        send_all();
        repeat (40) @(negedge clk);
        chk("gap_busy_early", 32'(busy), 32'd1);
        repeat (20) @(negedge clk);
        chk("gap_busy_late", 32'(busy), 32'd0);
        cmdq = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h00};
        send_all();
        wait_idle("gap_idle");
        chk("gap_ntxn", bus_q.size(), 1);
        chk("gap_pulses", pulses - p0, 1);
        if (bus_q.size() == 1) begin
            chk("gap_wstrb", 32'(bus_q[0].wstrb), 32'h0);
            chk("gap_addr", bus_q[0].addr, 32'h0);
        end
        chk("gap_tx", tx_word(), 32'h44332211);
        chk("gap_ntx", tx_q.size(), 4);

        // Reset while a read is stuck in BUS.
        rsp_delay = -1;
        tx_q.delete();
        cmdq = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h00};
        send_all();
        repeat (3) @(negedge clk);
        chk("rstbus_valid_before", 32'(mem_valid), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rstbus_mem_valid", 32'(mem_valid), 32'd0);
        chk("rstbus_tx_valid", 32'(tx_valid), 32'd0);
        chk("rstbus_busy", 32'(busy), 32'd0);
        chk("rstbus_rx_ready", 32'(rx_ready), 32'd1);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rstbus_no_resp", tx_q.size(), 0);

        // Randomized commands against the reference model.
        for (int k = 0; k < 24; k++) begin
            kind = $urandom_range(0, 5);
            a = 32'h100 + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
            w = $urandom;
            dly = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 4));
            cmdq.delete();
            if (kind == 0) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'h57 || b == 8'h52) b = 8'h00;
                cmdq.push_back(b);
            end else begin
                cmdq.push_back(kind <= 2 ? 8'h57 : 8'h52);
                for (int j = 0; j < 4; j++) cmdq.push_back(8'((a >> (8 * j)) & 32'hFF));
                if (kind <= 2) for (int j = 0; j < 4; j++) cmdq.push_back(8'((w >> (8 * j)) & 32'hFF));
            end
            model_cmd(dly);
            rsp_delay = dly;
            tx_rand = 1'($urandom_range(0, 1));
            tx_q.delete();
            bus_q.delete();
            p0 = pulses;
            send_all();
            wait_idle($sformatf("rnd%0d_idle", k));
            chk($sformatf("rnd%0d_ntx", k), tx_q.size(), m_tx.size());
            for (int j = 0; j < m_tx.size() && j < tx_q.size(); j++)
                chk($sformatf("rnd%0d_tx%0d", k, j), 32'(tx_q[j]), 32'(m_tx[j]));
            chk($sformatf("rnd%0d_pulses", k), pulses - p0, m_pulse);
            chk($sformatf("rnd%0d_ntxn", k), bus_q.size(), 32'(m_txn));
            if (m_txn && bus_q.size() == 1) begin
                chk($sformatf("rnd%0d_addr", k), bus_q[0].addr, m_addr);
                chk($sformatf("rnd%0d_wstrb", k), 32'(bus_q[0].wstrb), 32'(m_wstrb));
                if (m_wstrb == 4'hF) chk($sformatf("rnd%0d_wdata", k), bus_q[0].wdata, m_wdata);
            end
            if (m_pulse == 1 && !m_txn) chk($sformatf("rnd%0d_timeout_cycles", k), last_v, TMO);
        end

        chk("bus_stable", bus_unstable, 0);
        chk("tx_stable", tx_unstable, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- Debug/loader bridge that acts as a bus initiator on the native PicoRV32-style memory bus (valid/ready, 32-bit addr/wdata/rdata, 4-bit wstrb).
- Decodes a byte-stream command protocol from a UART receiver's byte interface and issues single-word reads/writes.
- Returns responses on a UART transmitter's byte interface.
- Sits beside the CPU behind a bus arbiter, so firmware can be loaded and memory/IO peeked or poked over the serial link.

Parameters:
- TIMEOUT, 1024, bus cycles to wait for mem_ready before aborting a transfer; 0 = wait forever.
- GAP_TIMEOUT, 100000, idle cycles between command bytes before the parser returns to IDLE; 0 = disabled.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- rx_valid  in  1  received byte available.
- rx_data  in  8  received byte.
- rx_ready  out  1  byte accepted when rx_valid && rx_ready.
- tx_valid  out  1  response byte offered.
- tx_data  out  8  response byte.
- tx_ready  in  1  transmitter takes byte when tx_valid && tx_ready.
- mem_valid  out  1  bus request.
- mem_addr  out  32  word address; bits [1:0] always 0.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  byte strobes; 4'b1111 write, 4'b0000 read.
- mem_ready  in  1  responder completion.
- mem_rdata  in  32  read data, valid while mem_ready.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset is synchronous, active-low, and applies on any clk edge with reset_n=0.
  - Reset values: state IDLE, rx_ready=1, tx_valid=0, tx_data=0, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, busy=0, counters=0.
  - Reset mid-transfer drops mem_valid and tx_valid on the next edge; no partial response is sent.
- Protocol; multi-byte fields are little-endian, LSB first:
  - Write: 0x57 'W', addr[4], data[4]. Response 0x4B 'K'.
  - Read: 0x52 'R', addr[4]. Response data[4] (mem_rdata, LSB first).
  - Any other command byte: response 0x3F '?'; the parser returns to IDLE.
  - Bus timeout: response 0x54 'T' for both reads and writes, replacing the data or 'K'.
- States:
  - IDLE: rx_ready=1.
    - 'W' or 'R' -> ADDR with cnt=0; the command is latched.
    - Other byte -> RESP with 1 byte '?'.
  - ADDR: each accepted byte goes to addr[8*cnt+:8] and cnt increments.
    - After byte 3: 'W' -> DATA with cnt=0; 'R' -> BUS.
  - DATA: each accepted byte goes to wdata[8*cnt+:8]. After byte 3 -> BUS.
  - BUS: rx_ready=0.
    - mem_valid=1 is asserted on the first cycle in BUS (registered, one cycle after the last byte is accepted).
    - mem_addr={addr[31:2],2'b00}, mem_wdata, and mem_wstrb are held stable while mem_valid=1.
    - Completion is the cycle with mem_valid && mem_ready. On that edge mem_rdata is captured and mem_valid goes 0 (never asserted two cycles after ready). -> RESP.
    - A responder that returns mem_ready in the same cycle mem_valid rises is legal.
    - mem_ready while mem_valid=0 is ignored.
  - RESP: rx_ready=0. tx_valid=1 with tx_data = current response byte, held stable until tx_ready.
    - A byte index advances on each tx_valid && tx_ready.
    - After the last byte, tx_valid=0 on the next edge and the state returns to IDLE.
    - Back-to-back bytes are allowed when tx_ready stays high, at one byte per cycle.
- Bus timeout: the wait counter starts at 0 on entry to BUS and increments each cycle mem_ready is low.
  - When the counter reaches TIMEOUT without completion: mem_valid=0, -> RESP with 'T'.
  - A mem_ready arriving in the same cycle the limit is reached counts as completion, not timeout.
- Gap timeout: in ADDR or DATA, GAP_TIMEOUT consecutive cycles without an accepted byte -> IDLE silently, with no response.
- Bytes arriving while rx_ready=0 are not consumed. The upstream receiver buffers them or drops them under its own overrun policy.
- mem_addr bits [1:0] supplied by the host are discarded.

Test Plan:
1. Write: send 57 10 00 00 00 EF BE AD DE; responder readies 3 cycles after valid -> one transfer with mem_addr=0x00000010, mem_wdata=0xDEADBEEF, wstrb=1111; mem_valid high exactly 4 cycles; tx emits 4B.
2. Read: preload 0x02000008 with 0x12345678; send 52 08 00 00 02 with zero-wait ready -> wstrb=0000, mem_addr=0x02000008, tx bytes 78 56 34 12 in order; tx_ready toggled randomly and each byte held stable until accepted.
3. Timeout: TIMEOUT=16, mem_ready never asserted, send 52 00 00 00 03 -> mem_valid high exactly 16 cycles, then 0; tx emits 54; the next command is processed normally.
4. Bad command: send 41 -> tx 3F, no mem_valid pulse. Then send 57 with misaligned address 03 00 00 00 -> mem_addr=0x00000000.
5. Gap/reset: GAP_TIMEOUT=50, send 57 10 then idle 60 cycles, then 52 00 00 00 00 -> only a read occurs. Then assert reset_n=0 for 1 cycle while in BUS -> mem_valid=0, tx_valid=0 next edge, busy=0.
